prep_div_sqrt_mvp: RTL and testbench
====================================

Name: prep_div_sqrt_mvp

Overview:
Operand front end for the multi-precision div/sqrt unit. It accepts two packed IEEE operands (FP64/FP32/FP16/FP16ALT) with a start pulse, classifies them and unpacks them into hidden-bit mantissas left-aligned to 53 bits. Subnormals are normalized with a signed exponent. It hands a registered operand bundle plus a one-cycle Done pulse to the iteration core, which is the counterpart of the output normalize/round stage.

Parameters:
C_LZC_STEP, 53, max left-shift applied per NORM cycle (1..53); 53 = single-cycle normalize

Ports:
Clk_CI  in  1  clock
Rst_RI  in  1  synchronous active-high reset
Div_start_SI  in  1  start division (a/b)
Sqrt_start_SI  in  1  start sqrt (a); b ignored
Kill_SI  in  1  abort current operation
Format_sel_SI  in  2  0=FP32 1=FP64 2=FP16 3=FP16ALT
Operand_a_DI  in  64  packed operand a, right-aligned
Operand_b_DI  in  64  packed operand b, right-aligned
Ready_SO  out  1  high in IDLE; start accepted only then
Done_SO  out  1  one-cycle pulse, bundle valid
Mant_a_DO  out  53  a mantissa, bit52 = leading one
Mant_b_DO  out  53  b mantissa
Exp_a_DO  out  13  signed biased exponent of a
Exp_b_DO  out  13  signed biased exponent of b
Sign_z_DO  out  1  div: sign_a^sign_b; sqrt: sign_a
Div_SO  out  1  latched op type (1=div, 0=sqrt)
Inf_a_SO, Inf_b_SO, Zero_a_SO, Zero_b_SO, NaN_a_SO, NaN_b_SO  out  1 each  class flags
SNaN_SO  out  1  either checked operand is signalling NaN

Behaviour:
- Reset: state IDLE; Ready_SO=1; Done_SO=0; all data and flag outputs 0.
- FSM states:
  - IDLE: on Div_start_SI or Sqrt_start_SI, register the operands, format and op type, then go to UNPACK. If both starts are high, division wins.
  - UNPACK: field split per format. exp==0 and frac==0 -> Zero. exp==all-ones and frac==0 -> Inf. exp==all-ones and frac!=0 -> NaN; SNaN when frac MSB=0. Mantissa is {hidden, frac, zero pad}; hidden=0 when exp==0. Subnormal exponent is forced to 1. Exponent is zero-extended to 13 bits. Go to NORM.
  - NORM: while either mantissa has bit52=0 and is nonzero, shift left by min(lzc, C_LZC_STEP) and subtract the shift from its exponent (13-bit two's complement, may go negative). When both are normalized or zero, go to DONE. Latency from start to Done_SO is 3 cycles with default C_LZC_STEP; worst case is 2+ceil(52/C_LZC_STEP)+1.
  - DONE: Done_SO=1 for exactly one cycle; outputs are held stable until the next accepted start; go to IDLE.
- Operand b: in sqrt mode, b is not classified. All b flags and Mant_b/Exp_b are 0, and SNaN_SO reflects a only.
- Narrow formats: frac is left-aligned under bit52. FP32 pads 29 zeros, FP16 pads 42, FP16ALT pads 45. Upper input bits beyond the format width are ignored; no NaN-boxing check is made.
- Start outside IDLE: ignored; Ready_SO=0 in UNPACK, NORM and DONE.
- Kill_SI: in any non-IDLE state, the next state is IDLE and no Done_SO pulse is produced. Data outputs keep their last values. Kill in IDLE has no effect. If Kill and start are simultaneous in IDLE, start is accepted.
- Rst_RI mid-operation: behaves as reset; no Done_SO pulse.
- Zero mantissa: the shift loop never runs on a zero mantissa, so there is no infinite loop.

Optional Feature:
Macro PREP_DIV_SQRT_MVP_SPECIAL_BYPASS_EN.
- Defined: if any class flag (Zero/Inf/NaN on a, or on b for div) is set in UNPACK, skip NORM and go directly to DONE. Latency becomes 2 cycles and mantissa/exponent outputs are the unnormalized unpack values.
- Undefined: all operations pass through NORM.

Test Plan:
- FP32 div: a=0x3F800000, b=0x40000000 -> Done at start+3; Mant_a=1<<52, Exp_a=127, Exp_b=128, Sign_z=0, flags 0.
- FP32 sqrt: a=0x00000001 (minimum subnormal) -> Mant_a=1<<52, Exp_a=13'h1FEA (-22), Zero_a=0.
- FP64 div: a=0x7FF0000000000001, b=0xBFF0000000000000 -> NaN_a=1, SNaN_SO=1, Sign_z=1, Exp_b=1023.
- FP16 div: a=0x3C00, b=0x0000 -> Zero_b=1, Mant_a=1<<52, Exp_a=15. Repeat with the macro defined -> Done at start+2.
- C_LZC_STEP=8, FP64 a=0x0000000000000001 -> Done at start+10 (7 NORM cycles), Exp_a=13'h1FCD (-51).
- Kill_SI asserted one cycle after start -> no Done_SO, Ready_SO=1 next cycle. A second start issued while busy is ignored.

Source files
------------

// File: rtl/prep_div_sqrt_mvp_if.sv
// Operand handshake and unpacked-bundle bus between the issuing stage and the
// div/sqrt operand front end.
interface prep_div_sqrt_mvp_if;
  logic        Div_start_SI;
  logic        Sqrt_start_SI;
  logic        Kill_SI;
  logic [1:0]  Format_sel_SI;
  logic [63:0] Operand_a_DI;
  logic [63:0] Operand_b_DI;
  logic        Ready_SO;
  logic        Done_SO;
  logic [52:0] Mant_a_DO;
  logic [52:0] Mant_b_DO;
  logic [12:0] Exp_a_DO;
  logic [12:0] Exp_b_DO;
  logic        Sign_z_DO;
  logic        Div_SO;
  logic        Inf_a_SO, Inf_b_SO, Zero_a_SO, Zero_b_SO, NaN_a_SO, NaN_b_SO;
  logic        SNaN_SO;

  modport master (
    output Div_start_SI, Sqrt_start_SI, Kill_SI, Format_sel_SI, Operand_a_DI, Operand_b_DI,
    input  Ready_SO, Done_SO, Mant_a_DO, Mant_b_DO, Exp_a_DO, Exp_b_DO, Sign_z_DO, Div_SO,
    input  Inf_a_SO, Inf_b_SO, Zero_a_SO, Zero_b_SO, NaN_a_SO, NaN_b_SO, SNaN_SO
  );
  modport slave (
    input  Div_start_SI, Sqrt_start_SI, Kill_SI, Format_sel_SI, Operand_a_DI, Operand_b_DI,
    output Ready_SO, Done_SO, Mant_a_DO, Mant_b_DO, Exp_a_DO, Exp_b_DO, Sign_z_DO, Div_SO,
    output Inf_a_SO, Inf_b_SO, Zero_a_SO, Zero_b_SO, NaN_a_SO, NaN_b_SO, SNaN_SO
  );
endinterface

// File: rtl/prep_div_sqrt_mvp.sv
// Div/sqrt operand front end: classify, unpack and normalize two IEEE operands.
// Optional PREP_DIV_SQRT_MVP_SPECIAL_BYPASS_EN skips NORM when a special class is seen.
module prep_div_sqrt_mvp #(
  parameter int C_LZC_STEP = 53
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  prep_div_sqrt_mvp_if.slave   io
);
  localparam logic [5:0] STEP = 6'(C_LZC_STEP);

  typedef enum logic [1:0] {IDLE, UNPACK, NORM, DONE} state_e;
  typedef struct packed {
    logic        sign;
    logic [12:0] exp;
    logic [52:0] mant;
    logic        zero, inf, nan, snan;
  } unp_t;

  function automatic unp_t unpack(input logic [63:0] op, input logic [1:0] fmt);
    unp_t        r;
    logic [10:0] e;
    logic [51:0] f;
    logic        emax, ezero;
    case (fmt)
      2'd0:    begin r.sign = op[31]; e = {3'b0, op[30:23]}; f = {op[22:0], 29'b0}; emax = &op[30:23]; end
      2'd1:    begin r.sign = op[63]; e = op[62:52];         f = op[51:0];          emax = &op[62:52]; end
      2'd2:    begin r.sign = op[15]; e = {6'b0, op[14:10]}; f = {op[9:0], 42'b0};  emax = &op[14:10]; end
      default: begin r.sign = op[15]; e = {3'b0, op[14:7]};  f = {op[6:0], 45'b0};  emax = &op[14:7];  end
    endcase
    ezero  = (e == '0);
    r.zero = ezero & (f == '0);
    r.inf  = emax & (f == '0);
    r.nan  = emax & (f != '0);
    r.snan = r.nan & ~f[51];
    r.mant = {~ezero, f};
    // subnormals get exponent 1 so the hidden-bit-free mantissa keeps its weight
    r.exp  = (ezero & ~r.zero) ? 13'd1 : {2'b0, e};
    return r;
  endfunction

  function automatic logic [5:0] lzc53(input logic [52:0] m);
    logic [5:0] n;
    n = 6'd53;
    for (int i = 0; i < 53; i++) if (m[i]) n = 6'(52 - i);
    return n;
  endfunction

  state_e      state_q;
  logic [63:0] opa_q, opb_q;
  logic [1:0]  fmt_q;
  logic        div_q, ready_q, done_q, sign_z_q;
  logic [52:0] mant_a_q, mant_b_q, mant_a_d, mant_b_d;
  logic [12:0] exp_a_q, exp_b_q, exp_a_d, exp_b_d;
  logic        inf_a_q, inf_b_q, zero_a_q, zero_b_q, nan_a_q, nan_b_q, snan_q;
  unp_t        ua, ub;
  logic        ok_a, ok_b;
  logic [5:0]  lz_a, lz_b, sh_a, sh_b;

  always_comb begin
    ua       = unpack(opa_q, fmt_q);
    ub       = div_q ? unpack(opb_q, fmt_q) : '0;
    ok_a     = mant_a_q[52] | (mant_a_q == '0);
    ok_b     = mant_b_q[52] | (mant_b_q == '0);
    lz_a     = lzc53(mant_a_q);
    lz_b     = lzc53(mant_b_q);
    sh_a     = ok_a ? 6'd0 : ((lz_a > STEP) ? STEP : lz_a);
    sh_b     = ok_b ? 6'd0 : ((lz_b > STEP) ? STEP : lz_b);
    mant_a_d = mant_a_q << sh_a;
    mant_b_d = mant_b_q << sh_b;
    exp_a_d  = exp_a_q - {7'b0, sh_a};
    exp_b_d  = exp_b_q - {7'b0, sh_b};
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      fmt_q    <= '0;
      div_q    <= 1'b0;
      sign_z_q <= 1'b0;
      mant_a_q <= '0;
      mant_b_q <= '0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      {inf_a_q, inf_b_q, zero_a_q, zero_b_q, nan_a_q, nan_b_q, snan_q} <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io.Div_start_SI || io.Sqrt_start_SI) begin
            opa_q   <= io.Operand_a_DI;
            opb_q   <= io.Operand_b_DI;
            fmt_q   <= io.Format_sel_SI;
            div_q   <= io.Div_start_SI;
            ready_q <= 1'b0;
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          if (io.Kill_SI) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            mant_a_q <= ua.mant;
            mant_b_q <= ub.mant;
            exp_a_q  <= ua.exp;
            exp_b_q  <= ub.exp;
            sign_z_q <= ua.sign ^ (div_q & ub.sign);
            {inf_a_q, inf_b_q}   <= {ua.inf, ub.inf};
            {zero_a_q, zero_b_q} <= {ua.zero, ub.zero};
            {nan_a_q, nan_b_q}   <= {ua.nan, ub.nan};
            snan_q   <= ua.snan | ub.snan;
`ifdef PREP_DIV_SQRT_MVP_SPECIAL_BYPASS_EN
            if (ua.zero | ua.inf | ua.nan | ub.zero | ub.inf | ub.nan) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= NORM;
            end
`else
            state_q  <= NORM;
`endif
          end
        end
        NORM: begin
          if (io.Kill_SI) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else if (ok_a && ok_b) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            mant_a_q <= mant_a_d;
            mant_b_q <= mant_b_d;
            exp_a_q  <= exp_a_d;
            exp_b_q  <= exp_b_d;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign io.Ready_SO  = ready_q;
  assign io.Done_SO   = done_q;
  assign io.Mant_a_DO = mant_a_q;
  assign io.Mant_b_DO = mant_b_q;
  assign io.Exp_a_DO  = exp_a_q;
  assign io.Exp_b_DO  = exp_b_q;
  assign io.Sign_z_DO = sign_z_q;
  assign io.Div_SO    = div_q;
  assign io.Inf_a_SO  = inf_a_q;
  assign io.Inf_b_SO  = inf_b_q;
  assign io.Zero_a_SO = zero_a_q;
  assign io.Zero_b_SO = zero_b_q;
  assign io.NaN_a_SO  = nan_a_q;
  assign io.NaN_b_SO  = nan_b_q;
  assign io.SNaN_SO   = snan_q;
endmodule

// File: tb/tb_prep_div_sqrt_mvp.sv
// Directed bench for prep_div_sqrt_mvp: a default instance and a C_LZC_STEP=8 instance.
module tb_prep_div_sqrt_mvp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prep_div_sqrt_mvp_if f0 ();
  prep_div_sqrt_mvp_if f8 ();
  prep_div_sqrt_mvp                     dut  (.Clk_CI(clk), .Rst_RI(rst), .io(f0.slave));
  prep_div_sqrt_mvp #(.C_LZC_STEP(8))   dut8 (.Clk_CI(clk), .Rst_RI(rst), .io(f8.slave));

`ifdef PREP_DIV_SQRT_MVP_SPECIAL_BYPASS_EN
  localparam int LAT_SPECIAL = 2;
`else
  localparam int LAT_SPECIAL = 3;
`endif
  localparam logic [52:0] ONE = 53'h10_0000_0000_0000;

  int vec  = 0;
  int miss = 0;

  function automatic logic [6:0] flags0();
    return {f0.Inf_a_SO, f0.Inf_b_SO, f0.Zero_a_SO, f0.Zero_b_SO, f0.NaN_a_SO, f0.NaN_b_SO, f0.SNaN_SO};
  endfunction

  task automatic set_in(input logic d, input logic s, input logic k, input logic [1:0] fmt,
                        input logic [63:0] a, input logic [63:0] b);
    f0.Div_start_SI = d; f0.Sqrt_start_SI = s; f0.Kill_SI = k;
    f0.Format_sel_SI = fmt; f0.Operand_a_DI = a; f0.Operand_b_DI = b;
    f8.Div_start_SI = d; f8.Sqrt_start_SI = s; f8.Kill_SI = k;
    f8.Format_sel_SI = fmt; f8.Operand_a_DI = a; f8.Operand_b_DI = b;
  endtask

  task automatic clr_ctl();
    f0.Div_start_SI = 0; f0.Sqrt_start_SI = 0; f0.Kill_SI = 0;
    f8.Div_start_SI = 0; f8.Sqrt_start_SI = 0; f8.Kill_SI = 0;
  endtask

  // Latency = negedges after the start was driven until Done is seen (-1 on timeout).
  task automatic run_op(input logic d, input logic s, input logic k, input logic [1:0] fmt,
                        input logic [63:0] a, input logic [63:0] b, output int lat0, output int lat8);
    @(negedge clk);
    set_in(d, s, k, fmt, a, b);
    lat0 = -1; lat8 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) clr_ctl();
      if (lat0 < 0 && f0.Done_SO) lat0 = n;
      if (lat8 < 0 && f8.Done_SO) lat8 = n;
      if (lat0 >= 0 && lat8 >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 2'd0, 64'h0, 64'h0);
    repeat (2) @(negedge clk);
    vec++; if (f0.Ready_SO !== 1'b1) begin miss++; $display("FAIL reset_ready got %b want 1", f0.Ready_SO); end
    vec++; if (f0.Done_SO !== 1'b0) begin miss++; $display("FAIL reset_done got %b want 0", f0.Done_SO); end
    vec++; if ({f0.Mant_a_DO, f0.Exp_a_DO, f0.Mant_b_DO, f0.Exp_b_DO} !== '0) begin
      miss++; $display("FAIL reset_data got %h/%h want 0", f0.Mant_a_DO, f0.Exp_a_DO); end
    vec++; if (flags0() !== 7'b0) begin miss++; $display("FAIL reset_flags got %b want 0", flags0()); end
    rst = 1'b0;
  endtask

  task automatic test_fp32_div();
    int l0, l8;
    run_op(1, 0, 0, 2'd0, 64'h3F80_0000, 64'h4000_0000, l0, l8);
    vec++; if (l0 !== 3) begin miss++; $display("FAIL div32_lat got %0d want 3", l0); end
    vec++; if (f0.Mant_a_DO !== ONE) begin miss++; $display("FAIL div32_mant_a got %h want %h", f0.Mant_a_DO, ONE); end
    vec++; if (f0.Mant_b_DO !== ONE) begin miss++; $display("FAIL div32_mant_b got %h want %h", f0.Mant_b_DO, ONE); end
    vec++; if (f0.Exp_a_DO !== 13'd127) begin miss++; $display("FAIL div32_exp_a got %0d want 127", f0.Exp_a_DO); end
    vec++; if (f0.Exp_b_DO !== 13'd128) begin miss++; $display("FAIL div32_exp_b got %0d want 128", f0.Exp_b_DO); end
    vec++; if ({f0.Sign_z_DO, f0.Div_SO} !== 2'b01) begin miss++; $display("FAIL div32_sign_div got %b want 01", {f0.Sign_z_DO, f0.Div_SO}); end
    vec++; if (flags0() !== 7'b0) begin miss++; $display("FAIL div32_flags got %b want 0", flags0()); end
    vec++; if (f0.Ready_SO !== 1'b0) begin miss++; $display("FAIL div32_ready_in_done got %b want 0", f0.Ready_SO); end
    @(negedge clk);
    vec++; if ({f0.Done_SO, f0.Ready_SO} !== 2'b01) begin miss++; $display("FAIL div32_pulse got %b want 01", {f0.Done_SO, f0.Ready_SO}); end
    vec++; if (f0.Exp_b_DO !== 13'd128) begin miss++; $display("FAIL div32_hold got %0d want 128", f0.Exp_b_DO); end
  endtask

  task automatic test_fp32_sqrt_subnormal();
    int l0, l8;
    run_op(0, 1, 0, 2'd0, 64'h1, 64'h7F80_0001, l0, l8);
    vec++; if (l0 !== 4) begin miss++; $display("FAIL sqrt_sub_lat got %0d want 4", l0); end
    vec++; if (f0.Mant_a_DO !== ONE) begin miss++; $display("FAIL sqrt_sub_mant got %h want %h", f0.Mant_a_DO, ONE); end
    vec++; if (f0.Exp_a_DO !== 13'h1FEA) begin miss++; $display("FAIL sqrt_sub_exp got %h want 1fea", f0.Exp_a_DO); end
    vec++; if ({f0.Mant_b_DO, f0.Exp_b_DO} !== '0) begin miss++; $display("FAIL sqrt_b_data got %h want 0", f0.Mant_b_DO); end
    vec++; if (flags0() !== 7'b0) begin miss++; $display("FAIL sqrt_flags got %b want 0", flags0()); end
    vec++; if (f0.Div_SO !== 1'b0) begin miss++; $display("FAIL sqrt_div got %b want 0", f0.Div_SO); end
  endtask

  task automatic test_fp64_nan();
    int l0, l8;
    run_op(1, 0, 0, 2'd1, 64'h7FF0_0000_0000_0001, 64'hBFF0_0000_0000_0000, l0, l8);
    vec++; if (l0 !== LAT_SPECIAL) begin miss++; $display("FAIL nan64_lat got %0d want %0d", l0, LAT_SPECIAL); end
    vec++; if (flags0() !== 7'b0000101) begin miss++; $display("FAIL nan64_flags got %b want 0000101", flags0()); end
    vec++; if (f0.Sign_z_DO !== 1'b1) begin miss++; $display("FAIL nan64_sign got %b want 1", f0.Sign_z_DO); end
    vec++; if (f0.Exp_b_DO !== 13'd1023) begin miss++; $display("FAIL nan64_exp_b got %0d want 1023", f0.Exp_b_DO); end
    vec++; if (f0.Mant_a_DO !== (ONE | 53'h1)) begin miss++; $display("FAIL nan64_mant_a got %h want %h", f0.Mant_a_DO, ONE | 53'h1); end
  endtask

  task automatic test_fp16_zero();
    int l0, l8;
    run_op(1, 0, 0, 2'd2, 64'h3C00, 64'h0, l0, l8);
    vec++; if (l0 !== LAT_SPECIAL) begin miss++; $display("FAIL z16_lat got %0d want %0d", l0, LAT_SPECIAL); end
    vec++; if (flags0() !== 7'b0001000) begin miss++; $display("FAIL z16_flags got %b want 0001000", flags0()); end
    vec++; if (f0.Mant_a_DO !== ONE) begin miss++; $display("FAIL z16_mant_a got %h want %h", f0.Mant_a_DO, ONE); end
    vec++; if (f0.Exp_a_DO !== 13'd15) begin miss++; $display("FAIL z16_exp_a got %0d want 15", f0.Exp_a_DO); end
    vec++; if (f0.Mant_b_DO !== 53'h0) begin miss++; $display("FAIL z16_mant_b got %h want 0", f0.Mant_b_DO); end
  endtask

  task automatic test_fp16alt_inf();
    int l0, l8;
    // high garbage above the 16-bit format must be ignored
    run_op(1, 0, 0, 2'd3, 64'hDEAD_0000_0000_BF80, 64'h7F80, l0, l8);
    vec++; if (l0 !== LAT_SPECIAL) begin miss++; $display("FAIL bf16_lat got %0d want %0d", l0, LAT_SPECIAL); end
    vec++; if (flags0() !== 7'b0100000) begin miss++; $display("FAIL bf16_flags got %b want 0100000", flags0()); end
    vec++; if (f0.Exp_a_DO !== 13'd127) begin miss++; $display("FAIL bf16_exp_a got %0d want 127", f0.Exp_a_DO); end
    vec++; if (f0.Sign_z_DO !== 1'b1) begin miss++; $display("FAIL bf16_sign got %b want 1", f0.Sign_z_DO); end
  endtask

  task automatic test_step8();
    int l0, l8;
    run_op(1, 0, 0, 2'd1, 64'h1, 64'h3FF0_0000_0000_0000, l0, l8);
    vec++; if (l8 !== 10) begin miss++; $display("FAIL step8_lat got %0d want 10", l8); end
    vec++; if (f8.Exp_a_DO !== 13'h1FCD) begin miss++; $display("FAIL step8_exp_a got %h want 1fcd", f8.Exp_a_DO); end
    vec++; if (f8.Mant_a_DO !== ONE) begin miss++; $display("FAIL step8_mant_a got %h want %h", f8.Mant_a_DO, ONE); end
    vec++; if (f8.Exp_b_DO !== 13'd1023) begin miss++; $display("FAIL step8_exp_b got %0d want 1023", f8.Exp_b_DO); end
    vec++; if (l0 !== 4) begin miss++; $display("FAIL step53_lat got %0d want 4", l0); end
    vec++; if (f0.Exp_a_DO !== 13'h1FCD) begin miss++; $display("FAIL step53_exp_a got %h want 1fcd", f0.Exp_a_DO); end
  endtask

  task automatic test_kill();
    int seen = 0;
    @(negedge clk);
    set_in(1, 0, 0, 2'd0, 64'h4040_0000, 64'h3F80_0000);
    @(negedge clk);
    clr_ctl(); f0.Kill_SI = 1; f8.Kill_SI = 1;
    @(negedge clk);
    clr_ctl();
    vec++; if (f0.Ready_SO !== 1'b1) begin miss++; $display("FAIL kill_ready got %b want 1", f0.Ready_SO); end
    for (int n = 0; n < 6; n++) begin
      if (f0.Done_SO) seen++;
      @(negedge clk);
    end
    vec++; if (seen !== 0) begin miss++; $display("FAIL kill_no_done got %0d pulses want 0", seen); end
    vec++; if (f0.Exp_a_DO !== 13'h1FCD) begin miss++; $display("FAIL kill_hold got %h want 1fcd", f0.Exp_a_DO); end
  endtask

  task automatic test_busy_start();
    int lat = -1, extra = 0;
    @(negedge clk);
    set_in(1, 0, 0, 2'd0, 64'h4040_0000, 64'h3F80_0000);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) set_in(0, 1, 0, 2'd1, 64'h1, 64'h0);
      if (n == 2) clr_ctl();
      if (f0.Done_SO) begin lat = n; break; end
    end
    vec++; if (lat !== 3) begin miss++; $display("FAIL busy_lat got %0d want 3", lat); end
    vec++; if (f0.Mant_a_DO !== 53'h18_0000_0000_0000) begin miss++; $display("FAIL busy_mant_a got %h want 18000000000000", f0.Mant_a_DO); end
    vec++; if ({f0.Div_SO, f0.Exp_a_DO} !== {1'b1, 13'd128}) begin miss++; $display("FAIL busy_op got %b/%0d want 1/128", f0.Div_SO, f0.Exp_a_DO); end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (f0.Done_SO) extra++;
    end
    vec++; if (extra !== 0) begin miss++; $display("FAIL busy_second_done got %0d want 0", extra); end
  endtask

  task automatic test_both_and_kill_start();
    int l0, l8;
    run_op(1, 1, 1, 2'd0, 64'hBF80_0000, 64'h4000_0000, l0, l8);
    vec++; if (l0 !== 3) begin miss++; $display("FAIL both_lat got %0d want 3", l0); end
    vec++; if ({f0.Div_SO, f0.Sign_z_DO, f0.Exp_b_DO} !== {2'b11, 13'd128}) begin
      miss++; $display("FAIL both_div got %b%b/%0d want 11/128", f0.Div_SO, f0.Sign_z_DO, f0.Exp_b_DO); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    set_in(0, 1, 0, 2'd0, 64'h1, 64'h0);
    @(negedge clk);
    clr_ctl();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++; if ({f0.Ready_SO, f0.Done_SO} !== 2'b10) begin miss++; $display("FAIL rstmid_ctl got %b want 10", {f0.Ready_SO, f0.Done_SO}); end
    vec++; if ({f0.Mant_a_DO, f0.Exp_a_DO} !== '0) begin miss++; $display("FAIL rstmid_data got %h want 0", f0.Mant_a_DO); end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (f0.Done_SO) seen++;
    end
    vec++; if (seen !== 0) begin miss++; $display("FAIL rstmid_no_done got %0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_fp32_div();
    test_fp32_sqrt_subnormal();
    test_fp64_nan();
    test_fp16_zero();
    test_fp16alt_inf();
    test_step8();
    test_kill();
    test_busy_start();
    test_both_and_kill_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
